// File: rtl/traffic_fsm_multi.sv
// rtl/traffic_fsm_multi.sv - main/side-road traffic light FSM with round-robin side selection
// Optional: define ALL_RED_EN to insert an all-red clearance interval after every yellow and walk.
module traffic_fsm_multi #(
  parameter int NUM_PHASES  = 2,
  parameter int ADDR_W      = 3,
  parameter int BASE_ADD    = 0,
  parameter int EXT_ADD     = 1,
  parameter int YEL_ADD     = 2,
  parameter int WALK_ADD    = 3,
  parameter int ALL_RED_ADD = 4
) (
  input  logic                  clk,
  input  logic                  sys_reset,
  input  logic                  prg_sync_in,
  input  logic                  expired,
  input  logic [NUM_PHASES-1:0] sensor_sync_in,
  input  logic                  walkRegister_status,
  output logic                  start_timer,
  output logic [ADDR_W-1:0]     interval_address,
  output logic                  walkRegister_reset,
  output logic [3*NUM_PHASES:0] light_signals
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam int LW = 3 * NUM_PHASES + 1;
  localparam logic [ADDR_W-1:0] A_BASE   = ADDR_W'(BASE_ADD);
  localparam logic [ADDR_W-1:0] A_EXT    = ADDR_W'(EXT_ADD);
  localparam logic [ADDR_W-1:0] A_YEL    = ADDR_W'(YEL_ADD);
  localparam logic [ADDR_W-1:0] A_WALK   = ADDR_W'(WALK_ADD);
  localparam logic [ADDR_W-1:0] A_ALLRED = ADDR_W'(ALL_RED_ADD);
  localparam logic [PW-1:0]     MAIN      = '0;
  localparam logic [PW-1:0]     LAST_SIDE = PW'(NUM_PHASES - 1);

  typedef enum logic [2:0] {GREEN_START, GREEN_EXT, YELLOW, WALK, ALL_RED} state_t;

  state_t            state, n_state, x_state;
  logic [PW-1:0]     cur_phase, n_phase, x_phase;
  logic [PW-1:0]     last_side, n_last, next_side, cand;
  logic [ADDR_W-1:0] n_addr, x_addr;
  logic              n_wrst, load, found, x_take;
`ifdef ALL_RED_EN
  logic              from_walk, n_from_walk;
`else
  logic              unused_all_red_addr;
  assign unused_all_red_addr = ^A_ALLRED;
`endif

  function automatic logic [PW-1:0] side_after(input logic [PW-1:0] s);
    return (s >= LAST_SIDE) ? PW'(1) : s + PW'(1);
  endfunction

  function automatic logic [LW-1:0] lights_for(input state_t s, input logic [PW-1:0] ph);
    logic [LW-1:0] l;
    l = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if ((s == GREEN_START || s == GREEN_EXT) && ph == PW'(p)) l[3*(NUM_PHASES-p)-2] = 1'b1;
      else if (s == YELLOW && ph == PW'(p))                     l[3*(NUM_PHASES-p)-1] = 1'b1;
      else                                                      l[3*(NUM_PHASES-p)]   = 1'b1;
    end
    l[0] = (s == WALK);
    return l;
  endfunction

  // First demanding side road after last_side; plain rotation when nobody is waiting.
  always_comb begin
    next_side = side_after(last_side);
    found     = 1'b0;
    cand      = last_side;
    for (int i = 1; i < NUM_PHASES; i++) begin
      cand = side_after(cand);
      if (!found && sensor_sync_in[cand]) begin
        next_side = cand;
        found     = 1'b1;
      end
    end
  end

  // Where the sequence goes once a yellow (and any clearance) is over.
  always_comb begin
    x_state = GREEN_START;
    x_phase = next_side;
    x_addr  = A_BASE;
    x_take  = 1'b1;
    if (cur_phase != MAIN) begin
      x_phase = MAIN;
      x_take  = 1'b0;
    end else if (walkRegister_status) begin
      x_state = WALK;
      x_phase = MAIN;
      x_addr  = A_WALK;
      x_take  = 1'b0;
    end
  end

  always_comb begin
    n_state = state;
    n_phase = cur_phase;
    n_last  = last_side;
    n_addr  = interval_address;
    n_wrst  = 1'b0;
    load    = prg_sync_in || (expired && !start_timer);
`ifdef ALL_RED_EN
    n_from_walk = from_walk;
`endif
    if (prg_sync_in) begin
      n_state = GREEN_START;
      n_phase = MAIN;
      n_last  = LAST_SIDE;
      n_addr  = A_BASE;
`ifdef ALL_RED_EN
      n_from_walk = 1'b0;
`endif
    end else begin
      case (state)
        GREEN_START: begin
          if (cur_phase == MAIN || sensor_sync_in[cur_phase]) begin
            n_state = GREEN_EXT;
            n_addr  = sensor_sync_in[cur_phase] ? A_EXT : A_BASE;
          end else begin
            n_state = YELLOW;
            n_addr  = A_YEL;
          end
        end
        GREEN_EXT: begin
          n_state = YELLOW;
          n_addr  = A_YEL;
        end
        YELLOW: begin
`ifdef ALL_RED_EN
          n_state     = ALL_RED;
          n_addr      = A_ALLRED;
          n_from_walk = 1'b0;
`else
          n_state = x_state;
          n_phase = x_phase;
          n_addr  = x_addr;
          if (x_take) n_last = next_side;
`endif
        end
        WALK: begin
          n_wrst = 1'b1;
`ifdef ALL_RED_EN
          n_state     = ALL_RED;
          n_addr      = A_ALLRED;
          n_from_walk = 1'b1;
`else
          n_state = GREEN_START;
          n_phase = next_side;
          n_last  = next_side;
          n_addr  = A_BASE;
`endif
        end
        default: begin
`ifdef ALL_RED_EN
          if (from_walk) begin
            n_state = GREEN_START;
            n_phase = next_side;
            n_last  = next_side;
            n_addr  = A_BASE;
          end else begin
            n_state = x_state;
            n_phase = x_phase;
            n_addr  = x_addr;
            if (x_take) n_last = next_side;
          end
`else
          n_state = x_state;
          n_phase = x_phase;
          n_addr  = x_addr;
          if (x_take) n_last = next_side;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state              <= GREEN_START;
      cur_phase          <= MAIN;
      last_side          <= LAST_SIDE;
      interval_address   <= A_BASE;
      start_timer        <= 1'b1;
      walkRegister_reset <= 1'b0;
      light_signals      <= lights_for(GREEN_START, MAIN);
`ifdef ALL_RED_EN
      from_walk          <= 1'b0;
`endif
    end else if (load) begin
      state              <= n_state;
      cur_phase          <= n_phase;
      last_side          <= n_last;
      interval_address   <= n_addr;
      start_timer        <= 1'b1;
      walkRegister_reset <= n_wrst;
      light_signals      <= lights_for(n_state, n_phase);
`ifdef ALL_RED_EN
      from_walk          <= n_from_walk;
`endif
    end else begin
      start_timer        <= 1'b0;
      walkRegister_reset <= 1'b0;
    end
  end
endmodule

// File: tb/tb_traffic_fsm_multi.sv
// tb/tb_traffic_fsm_multi.sv - randomized bench for traffic_fsm_multi against a behavioural model
module tb_traffic_fsm_multi;
  localparam int NA = 2;
  localparam int NB = 4;
  localparam int M_GS = 0, M_GE = 1, M_Y = 2, M_W = 3, M_AR = 4;

  typedef struct {
    int mode; int phase; int last; int addr; bit start; bit wrst; bit from_walk;
  } mdl_t;

  logic clk = 1'b0;
  logic rst, prg, exp_a, exp_b, walk_a, walk_b;
  logic [NA-1:0] sens_a;
  logic [NB-1:0] sens_b;
  logic st_a, st_b, wr_a, wr_b;
  logic [2:0] ad_a, ad_b;
  logic [3*NA:0] li_a;
  logic [3*NB:0] li_b;

  int checks = 0, fails = 0;
  int tmode, tlen, cnt_a, cnt_b;
  mdl_t ma, mb;
  logic [24:0] la, lb;
  bit rec1, rec_hold, rec_walk, prev_st, walk_seen;
  logic [6:0] seq_l[$];
  int seq_ad[$], side_gs[$], ext_q[$];
  int ph2_green, hold_pulses, hold_consec, walk_pulses;
  logic [6:0] exp_l[4];
  int exp_ad[4];

  traffic_fsm_multi #(.NUM_PHASES(NA)) dut_a (
    .clk(clk), .sys_reset(rst), .prg_sync_in(prg), .expired(exp_a), .sensor_sync_in(sens_a),
    .walkRegister_status(walk_a), .start_timer(st_a), .interval_address(ad_a),
    .walkRegister_reset(wr_a), .light_signals(li_a));

  traffic_fsm_multi #(.NUM_PHASES(NB)) dut_b (
    .clk(clk), .sys_reset(rst), .prg_sync_in(prg), .expired(exp_b), .sensor_sync_in(sens_b),
    .walkRegister_status(walk_b), .start_timer(st_b), .interval_address(ad_b),
    .walkRegister_reset(wr_b), .light_signals(li_b));

  initial forever #5 clk = ~clk;

  function automatic mdl_t m_reset(int n);
    mdl_t r;
    r.mode = M_GS; r.phase = 0; r.last = n - 1; r.addr = 0;
    r.start = 1; r.wrst = 0; r.from_walk = 0;
    return r;
  endfunction

  function automatic int m_pick(int n, int last, logic [7:0] s);
    for (int i = 1; i < n; i++) begin
      int k;
      k = ((last - 1 + i) % (n - 1)) + 1;
      if (s[k]) return k;
    end
    return (last % (n - 1)) + 1;
  endfunction

  function automatic mdl_t m_side(mdl_t m, int n, logic [7:0] s);
    mdl_t r;
    r = m;
    r.phase = m_pick(n, m.last, s);
    r.last = r.phase; r.mode = M_GS; r.addr = 0;
    return r;
  endfunction

  function automatic mdl_t m_leave(mdl_t m, int n, logic [7:0] s, logic wk);
    mdl_t r;
    r = m;
    if (m.phase != 0) begin r.mode = M_GS; r.phase = 0; r.addr = 0; end
    else if (wk) begin r.mode = M_W; r.addr = 3; end
    else r = m_side(m, n, s);
    return r;
  endfunction

  function automatic mdl_t m_step(mdl_t m, int n, logic ex, logic [7:0] s, logic wk, logic pg);
    mdl_t r;
    if (pg) return m_reset(n);
    r = m; r.start = 0; r.wrst = 0;
    if (!ex || m.start) return r;
    r.start = 1;
    case (m.mode)
      M_GS: begin
        if (m.phase == 0 || s[m.phase]) begin r.mode = M_GE; r.addr = s[m.phase] ? 1 : 0; end
        else begin r.mode = M_Y; r.addr = 2; end
      end
      M_GE: begin r.mode = M_Y; r.addr = 2; end
      M_Y: begin
`ifdef ALL_RED_EN
        r.mode = M_AR; r.addr = 4; r.from_walk = 0;
`else
        r = m_leave(r, n, s, wk);
`endif
      end
      M_W: begin
        r.wrst = 1;
`ifdef ALL_RED_EN
        r.mode = M_AR; r.addr = 4; r.from_walk = 1;
`else
        r = m_side(r, n, s);
`endif
      end
      default: r = m.from_walk ? m_side(r, n, s) : m_leave(r, n, s, wk);
    endcase
    return r;
  endfunction

  function automatic logic [24:0] m_lights(mdl_t m, int n);
    logic [24:0] l;
    l = '0;
    for (int p = 0; p < n; p++) begin
      if (m.mode == M_W || m.mode == M_AR || p != m.phase) l[3*(n-p)] = 1'b1;
      else if (m.mode == M_Y) l[3*(n-p)-1] = 1'b1;
      else l[3*(n-p)-2] = 1'b1;
    end
    l[0] = (m.mode == M_W);
    return l;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model advances on the same edges as the DUTs.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ma = m_reset(NA);
      mb = m_reset(NB);
    end else begin
      ma = m_step(ma, NA, exp_a, 8'(sens_a), walk_a, prg);
      mb = m_step(mb, NB, exp_b, 8'(sens_b), walk_b, prg);
    end
  end

  // Compare and observation process, sampling away from the active edge.
  initial forever begin
    @(negedge clk);
    la = m_lights(ma, NA);
    lb = m_lights(mb, NB);
    chk("light_a", 32'(li_a), 32'(la[3*NA:0]));
    chk("addr_a",  32'(ad_a), 32'(ma.addr));
    chk("start_a", 32'(st_a), 32'(ma.start));
    chk("wrst_a",  32'(wr_a), 32'(ma.wrst));
    chk("light_b", 32'(li_b), 32'(lb[3*NB:0]));
    chk("addr_b",  32'(ad_b), 32'(mb.addr));
    chk("start_b", 32'(st_b), 32'(mb.start));
    chk("wrst_b",  32'(wr_b), 32'(mb.wrst));
    if (rec1 && st_a) begin seq_l.push_back(li_a); seq_ad.push_back(int'(ad_a)); end
    if (rec1)
      for (int p = 1; p < NB; p++)
        if (li_b[3*(NB-p)-2]) begin
          if (p == 2) ph2_green++;
          if (st_b && ad_b == 3'd0) side_gs.push_back(p);
          if (st_b && ad_b == 3'd1) ext_q.push_back(p);
        end
    if (rec_hold) begin
      if (st_a) hold_pulses++;
      if (st_a && prev_st) hold_consec++;
    end
    prev_st = st_a;
    if (rec_walk) begin
      if (wr_a) walk_pulses++;
      if (li_a == 7'b1001001 && ad_a == 3'd3) walk_seen = 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (ma.start) cnt_a = 0; else cnt_a++;
    if (mb.start) cnt_b = 0; else cnt_b++;
    if (ma.wrst) walk_a = 0;
    if (mb.wrst) walk_b = 0;
    case (tmode)
      0: begin exp_a = (cnt_a >= tlen); exp_b = (cnt_b >= tlen); end
      1: begin exp_a = 1'b1; exp_b = 1'b1; end
      default: begin exp_a = ($urandom % 3 == 0); exp_b = ($urandom % 3 == 0); end
    endcase
  endtask

  initial begin
`ifdef ALL_RED_EN
    exp_l = '{7'b0011000, 7'b0101000, 7'b1001000, 7'b1000010};
    exp_ad = '{0, 2, 4, 0};
`else
    exp_l = '{7'b0011000, 7'b0101000, 7'b1000010, 7'b1000100};
    exp_ad = '{0, 2, 0, 2};
`endif
    rst = 1; prg = 0; exp_a = 0; exp_b = 0; walk_a = 0; walk_b = 0;
    sens_a = '0; sens_b = '0; tmode = 0; tlen = 10; cnt_a = 0; cnt_b = 0;
    rec1 = 0; rec_hold = 0; rec_walk = 0; prev_st = 0; walk_seen = 0;
    ph2_green = 0; hold_pulses = 0; hold_consec = 0; walk_pulses = 0;
    repeat (3) tick();
    chk("rst_light_a", 32'(li_a), 32'(7'b0011000));
    chk("rst_light_b", 32'(li_b), 32'(13'b0011001001000));
    chk("rst_addr_a", 32'(ad_a), 32'd0);
    chk("rst_start_a", 32'(st_a), 32'd1);
    chk("rst_wrst_b", 32'(wr_b), 32'd0);

    // Fixed-interval sequencing; side road sensors 1 and 3 held on the 4-phase unit.
    sens_b = 4'b1010;
    rst = 0;
    rec1 = 1;
    for (int i = 0; i < 700 && !(seq_l.size() >= 4 && side_gs.size() >= 4 && ext_q.size() >= 2); i++) tick();
    rec1 = 0;
    chk("seq_len", 32'(seq_l.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < seq_l.size(); i++) begin
      chk("seq_light", 32'(seq_l[i]), 32'(exp_l[i]));
      chk("seq_addr", 32'(seq_ad[i]), 32'(exp_ad[i]));
    end
    chk("side_len", 32'(side_gs.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < side_gs.size(); i++)
      chk("side_order", 32'(side_gs[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    chk("ext_len", 32'(ext_q.size() >= 2), 32'd1);
    for (int i = 0; i < 2 && i < ext_q.size(); i++)
      chk("ext_side", 32'(ext_q[i]), (i == 0) ? 32'd1 : 32'd3);
    chk("phase2_never_green", 32'(ph2_green), 32'd0);

    // Single pedestrian request.
    tlen = 5;
    walk_a = 1;
    rec_walk = 1;
    repeat (150) tick();
    rec_walk = 0;
    chk("walk_seen", 32'(walk_seen), 32'd1);
    chk("walk_reset_pulses", 32'(walk_pulses), 32'd1);

    // Expired stuck high: one transition every second cycle.
    tmode = 1;
    repeat (4) tick();
    rec_hold = 1;
    repeat (20) tick();
    rec_hold = 0;
    chk("hold_pulses", 32'(hold_pulses), 32'd10);
    chk("hold_consecutive", 32'(hold_consec), 32'd0);

    // Reprogram strobe on an edge where a transition would otherwise fire.
    for (int i = 0; i < 4 && ma.start; i++) tick();
    prg = 1;
    tick();
    prg = 0;
    chk("prg_light_a", 32'(li_a), 32'(7'b0011000));
    chk("prg_addr_a", 32'(ad_a), 32'd0);
    chk("prg_start_a", 32'(st_a), 32'd1);
    chk("prg_light_b", 32'(li_b), 32'(13'b0011001001000));

    // Asynchronous reset in the middle of a walk interval.
    tmode = 0; tlen = 4; walk_a = 1;
    for (int i = 0; i < 200 && ma.mode != M_W; i++) tick();
    chk("reached_walk", 32'(ma.mode == M_W), 32'd1);
    chk("walk_light", 32'(li_a), 32'(7'b1001001));
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("async_light_a", 32'(li_a), 32'(7'b0011000));
    chk("async_addr_a", 32'(ad_a), 32'd0);
    chk("async_start_a", 32'(st_a), 32'd1);
    walk_a = 0;
    tick();
    tick();
    rst = 0;

    // Randomized traffic, pedestrians and occasional reprogramming.
    tmode = 2;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom % 20 == 0) begin
        sens_a = 2'($urandom_range(0, 3));
        sens_b = 4'($urandom_range(0, 15));
      end
      if ($urandom % 40 == 0) walk_a = 1;
      if ($urandom % 40 == 0) walk_b = 1;
      prg = ($urandom % 300 == 0);
    end
    prg = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/traffic_fsm_multi.md
Name: traffic_fsm_multi

Overview:
- Parametrised successor to the two-road traffic controller FSM: one main road (phase 0) plus NUM_PHASES-1 side roads, served main/side alternately with round-robin side selection.
- Drives the shared interval timer via the start_timer/expired handshake and an interval address.
- Controls per-phase red/yellow/green lights and one pedestrian walk light.
- With NUM_PHASES=2 and ALL_RED_EN undefined, its light encoding and sequencing match the existing two-road controller.

Parameters:
- NUM_PHASES, 2, road phases including main; legal range 2..8.
- ADDR_W, 3, interval_address width.
- BASE_ADD, 0, base green interval address.
- EXT_ADD, 1, extended green interval address.
- YEL_ADD, 2, yellow interval address.
- WALK_ADD, 3, pedestrian walk interval address.
- ALL_RED_ADD, 4, all-red clearance interval address (used only with ALL_RED_EN).

Ports:
- clk  in  1  system clock.
- sys_reset  in  1  asynchronous, active-high reset.
- prg_sync_in  in  1  synchronised reprogram strobe; synchronous restart.
- expired  in  1  interval timer expired.
- sensor_sync_in  in  NUM_PHASES  synchronised vehicle sensors; bit p belongs to phase p.
- walkRegister_status  in  1  latched pedestrian request.
- start_timer  out  1  one-cycle timer (re)start pulse.
- interval_address  out  ADDR_W  interval selector for the timer.
- walkRegister_reset  out  1  one-cycle clear pulse for the walk register.
- light_signals  out  3*NUM_PHASES+1  per-phase {R,Y,G}, phase 0 in the MSBs; walk light at bit 0.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- Values during sys_reset: state=GREEN_START, cur_phase=0, last_side=NUM_PHASES-1, interval_address=BASE_ADD, start_timer=1, walkRegister_reset=0. light_signals: phase 0 green, all other phases red, walk off.
- start_timer therefore stays high through reset and drops at the first clock edge after release, unless a transition occurs on that edge.
- prg_sync_in high at an edge loads the reset values, including start_timer=1. It overrides expired and every other input.
- Transition rule: a transition fires only on an edge where expired=1 and start_timer is currently 0. Expired in the cycle immediately after a start pulse is stale and ignored.
- On each transition: start_timer=1 for exactly one cycle, new interval_address and state are loaded, and light_signals is updated on the same edge.
- Otherwise start_timer=0 and walkRegister_reset=0.
- States: GREEN_START, GREEN_EXT, YELLOW, WALK, ALL_RED.
- GREEN_START, phase 0:
  - sensor bit set -> GREEN_EXT with EXT_ADD.
  - sensor bit clear -> GREEN_EXT with BASE_ADD.
- GREEN_START, side phase p:
  - sensor[p]=1 -> GREEN_EXT with EXT_ADD.
  - sensor[p]=0 -> YELLOW with YEL_ADD.
- GREEN_EXT -> YELLOW with YEL_ADD.
- YELLOW, phase 0:
  - walkRegister_status=1 -> WALK with WALK_ADD.
  - walkRegister_status=0 -> GREEN_START of next_side with BASE_ADD.
- YELLOW, side phase -> GREEN_START of phase 0 with BASE_ADD.
- WALK -> GREEN_START of next_side with BASE_ADD; walkRegister_reset=1 for one cycle on this edge.
- next_side: the first phase k with sensor_sync_in[k]=1, searching last_side+1, last_side+2, ... over 1..NUM_PHASES-1 with wrap-around.
  - If no side phase is demanding, next_side=last_side+1 (wrapping). A side phase is always served after main.
  - last_side<=next_side when that side phase is entered.
- Lights per state:
  - GREEN_START/GREEN_EXT: cur_phase green, others red.
  - YELLOW: cur_phase yellow, others red.
  - WALK: all red, walk on.
  - ALL_RED: all red, walk off.
- Exactly one of R/Y/G is set per phase at all times.

Optional Feature:
- Macro: ALL_RED_EN.
- When defined:
  - Every exit from YELLOW and from WALK first enters ALL_RED with ALL_RED_ADD.
  - The destination (WALK, phase 0, or next_side) is evaluated on ALL_RED expiry using the inputs present then.
  - walkRegister_reset pulses on the WALK->ALL_RED edge.
- When undefined: ALL_RED is unreachable, ALL_RED_ADD is unused, and transitions are direct as listed above.

Test Plan:
- Reset, NUM_PHASES=2, no sensors, no walk, timer expiring every 10 cycles -> light_signals cycles 0011000, 0011000, 0101000, 1000010, 1000100; addresses 0,0,2,0,2; start_timer is a single-cycle pulse per transition.
- NUM_PHASES=4, sensors 4'b1010 held -> side service order 1,3,1,3; phase 2 never green; both side greens use EXT_ADD.
- walkRegister_status=1 at main-yellow expiry -> WALK with address 3, lights all red + walk; walkRegister_reset pulses once on WALK exit.
- expired held high continuously -> exactly one transition every 2 cycles; never two consecutive start pulses.
- sys_reset asserted mid-WALK (asynchronous) -> outputs immediately show main green, address 0, start_timer=1. prg_sync_in together with expired -> restart wins.
- ALL_RED_EN defined, NUM_PHASES=3 -> every yellow is followed by all-red with address 4; a walk request raised during ALL_RED is honoured.
